// File: rtl/cafe_arbiter_if.sv
// Bus between cafe_arbiter and its surroundings (order entry plus the coffee machine).
//
// Handshake: req is a level held by each requester. The arbiter samples req only
// while it is arbitrating. It answers with a one-hot grant that is held from START
// through DONE (or through ERR). done pulses for one cycle on the granted bit when the
// brew completes. There is no back-pressure: a requester may drop req at any time
// after its grant without aborting the brew.
//
// Signals:
//   req           requester level requests, one bit per requester
//   err_clr       clears a sticky error (acted on only while in error)
//   machine_state the coffee machine's state output (IDLE = 1, legal 1..9)
//   start         one-cycle start strobe to the machine
//   grant         one-hot owner of the current brew, zero when idle
//   done          one-cycle completion pulse on the owner's bit
//   busy          a brew is in progress
//   error         timeout or illegal machine state seen
//   served_count  saturating count of completed brews
//   fsm_state     arbiter FSM state, for debug and checkers
//
// Modports: master is the arbiter side; slave is the order-entry/machine side.
interface cafe_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0] req;
  logic             err_clr;
  logic [3:0]       machine_state;
  logic             start;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic             busy;
  logic             error;
  logic [CNT_W-1:0] served_count;
  logic [2:0]       fsm_state;

  modport master (
    input  req, err_clr, machine_state,
    output start, grant, done, busy, error, served_count, fsm_state
  );

  modport slave (
    output req, err_clr, machine_state,
    input  start, grant, done, busy, error, served_count, fsm_state
  );
endinterface

// File: rtl/cafe_arbiter.sv
// Round-robin arbiter and brew sequencer sharing one coffee machine between
// N_REQ requesters. It grants when the machine reports IDLE, strobes start,
// follows the machine away from IDLE and back, then reports completion.
// Leave/run timeouts and illegal machine states park the FSM in a sticky error
// state that keeps grant so the failed owner stays visible.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cafe_arbiter_if.master (req, err_clr, machine_state in;
//        start, grant, done, busy, error, served_count, fsm_state out)
module cafe_arbiter #(
  parameter int N_REQ    = 4,
  parameter int LEAVE_TO = 8,
  parameter int RUN_TO   = 64,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  cafe_arbiter_if.master bus
);

  localparam int MAX_TO = (LEAVE_TO > RUN_TO) ? LEAVE_TO : RUN_TO;
  localparam int TMR_W  = $clog2(MAX_TO + 1);
  localparam int IDX_W  = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_ARB   = 3'd0,
    S_START = 3'd1,
    S_LEAVE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [IDX_W-1:0] ptr_q, ptr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             ms_active;
  logic             ms_bad;
  logic             ms_idle;

  assign ms_idle   = (bus.machine_state == 4'd1);
  assign ms_active = (bus.machine_state >= 4'd2) && (bus.machine_state <= 4'd9);
  assign ms_bad    = (bus.machine_state == 4'd0) || (bus.machine_state >= 4'd10);

  // Round-robin search: first set req bit starting just after the pointer.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The timer holds the number of earlier cycles spent in the current phase, so
  // the phase is over budget on the edge where timer + 1 reaches the limit.
  // Legal exits are tested first so they win over a timeout on the same edge.
  always_comb begin
    state_n = state;
    timer_n = timer;
    grant_n = grant_q;
    idx_n   = idx_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    case (state)
      S_ARB: begin
        if (win_found && ms_idle) begin
          grant_n          = '0;
          grant_n[win_idx] = 1'b1;
          idx_n            = win_idx;
          state_n          = S_START;
        end
      end
      S_START: begin
        timer_n = '0;
        state_n = S_LEAVE;
      end
      S_LEAVE: begin
        if (ms_active) begin
          timer_n = '0;
          state_n = S_RUN;
        end else if (ms_bad) begin
          state_n = S_ERR;
        end else if (timer == TMR_W'(LEAVE_TO - 1)) begin
          state_n = S_ERR;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      S_RUN: begin
        if (ms_idle) begin
          state_n = S_DONE;
        end else if (ms_bad) begin
          state_n = S_ERR;
        end else if (timer == TMR_W'(RUN_TO - 1)) begin
          state_n = S_ERR;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      S_DONE: begin
        if (!(&cnt_q)) cnt_n = cnt_q + CNT_W'(1);
        ptr_n   = idx_q;
        grant_n = '0;
        state_n = S_ARB;
      end
      S_ERR: begin
        if (bus.err_clr) begin
          grant_n = '0;
          state_n = S_ARB;
        end
      end
      default: begin
        grant_n = '0;
        state_n = S_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_ARB;
      timer   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      grant_q <= grant_n;
      idx_q   <= idx_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
    end
  end

  // Strobes are pure decodes of the registered state.
  assign bus.start        = (state == S_START);
  assign bus.busy         = (state == S_START) || (state == S_LEAVE) ||
                            (state == S_RUN)   || (state == S_DONE);
  assign bus.error        = (state == S_ERR);
  assign bus.done         = (state == S_DONE) ? grant_q : '0;
  assign bus.grant        = grant_q;
  assign bus.served_count = cnt_q;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_cafe_arbiter.sv
module tb_cafe_arbiter;
  localparam int N  = 4;
  localparam int LT = 8;
  localparam int RT = 64;

  logic clk;
  logic rst;

  cafe_arbiter_if #(.N_REQ(N), .CNT_W(8)) bus ();
  cafe_arbiter_if #(.N_REQ(N), .CNT_W(2)) bus2 ();

  cafe_arbiter #(.N_REQ(N), .LEAVE_TO(LT), .RUN_TO(RT), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy fed the same inputs, used for the saturation check.
  assign bus2.req           = bus.req;
  assign bus2.err_clr       = bus.err_clr;
  assign bus2.machine_state = bus.machine_state;

  cafe_arbiter #(.N_REQ(N), .LEAVE_TO(LT), .RUN_TO(RT), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_q[$];
  int last;
  int exp_cnt;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ms;
    logic       clr;
    logic       start;
    logic       busy;
    logic       error;
    logic [3:0] grant;
    logic [3:0] done;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference rule: scan requesters after the last served one, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int off = 1; off <= N; off++) begin
      if (r[(lst + off) % N]) return (lst + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  function automatic void add(input logic [3:0] r, input logic [3:0] m, input logic c,
                              input logic s, input logic b, input logic e,
                              input logic [3:0] g, input logic [3:0] d, input logic [7:0] n);
    vec_t v;
    v.req = r; v.ms = m; v.clr = c; v.start = s; v.busy = b; v.error = e;
    v.grant = g; v.done = d; v.cnt = n;
    tbl.push_back(v);
  endfunction

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.err_clr = 1'b0;
    bus.machine_state = 4'd0;
    step();
    step();
    rst = 1'b0;
    last = N - 1;
    exp_cnt = 0;
  endtask

  task automatic start_brew(output logic [N-1:0] g);
    int waited;
    waited = 0;
    bus.machine_state = 4'd1;
    while (bus.start !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    total++;
    if (bus.start !== 1'b1) begin
      bad++;
      $display("FAIL start_wait act=no_start exp=start_within_40");
    end
    g = bus.grant;
    step();
    chk("start_width", bus.start, 0);
  endtask

  // Full legal brew: d idle samples in LEAVE, l active samples, then back to IDLE.
  task automatic brew(input int d, input int l, input logic [N-1:0] req_after);
    logic [N-1:0] g;
    logic [N-1:0] e;
    e = exp_q[0];
    start_brew(g);
    chk("grant", g, e);
    bus.req = req_after;
    for (int i = 0; i < d; i++) begin
      bus.machine_state = 4'd1;
      step();
    end
    for (int i = 0; i < l; i++) begin
      bus.machine_state = 4'($urandom_range(9, 2));
      step();
    end
    bus.machine_state = 4'd1;
    step();
    e = exp_q.pop_front();
    chk("done", bus.done, e);
    chk("grant_in_done", bus.grant, e);
    step();
    chk("done_width", bus.done, 0);
    chk("grant_release", bus.grant, 0);
  endtask

  task automatic model_brew(input logic [N-1:0] r, input int d, input int l, input logic [N-1:0] ra);
    int w;
    w = rr_pick(r, last);
    exp_q.push_back(onehot(w));
    bus.req = r;
    brew(d, l, ra);
    last = w;
    exp_cnt++;
  endtask

  task automatic clear_err();
    bus.req = '0;
    bus.machine_state = 4'd1;
    bus.err_clr = 1'b1;
    step();
    chk("clr_error", bus.error, 0);
    chk("clr_grant", bus.grant, 0);
    step();
    chk("clr_held_error", bus.error, 0);
    chk("clr_held_busy", bus.busy, 0);
    bus.err_clr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_cnt"}, bus.served_count, 0);
    chk({tag, "_cnt_sat"}, bus2.served_count, 0);
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] r;
    int n;

    do_reset();
    chk_reset_outputs("reset");

    // single order with startup gate: machine at 0 for 10 cycles, then IDLE
    add(4'b0000, 4'd1, 1'b1, 0, 0, 0, 4'b0000, 4'b0000, 8'd0);
    for (int i = 0; i < 10; i++) add(4'b0001, 4'd0, 1'b0, 0, 0, 0, 4'b0000, 4'b0000, 8'd0);
    add(4'b0001, 4'd1, 1'b0, 1, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd1, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd2, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd3, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd4, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd3, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd5, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd6, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd7, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd8, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd9, 1'b0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0);
    add(4'b0001, 4'd1, 1'b0, 0, 1, 0, 4'b0001, 4'b0001, 8'd0);
    add(4'b0000, 4'd1, 1'b0, 0, 0, 0, 4'b0000, 4'b0000, 8'd1);
    add(4'b0000, 4'd1, 1'b0, 0, 0, 0, 4'b0000, 4'b0000, 8'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.req = tbl[i].req;
      bus.machine_state = tbl[i].ms;
      bus.err_clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_ctrl", i), {bus.start, bus.busy, bus.error},
          {tbl[i].start, tbl[i].busy, tbl[i].error});
      chk($sformatf("vec%0d_grant", i), bus.grant, tbl[i].grant);
      chk($sformatf("vec%0d_done", i), bus.done, tbl[i].done);
      chk($sformatf("vec%0d_cnt", i), bus.served_count, tbl[i].cnt);
    end
    bus.err_clr = 1'b0;

    // fairness: fixed expected order 0,1,3,0,1,3 from reset; last brew at both
    // timeout limits, where the legal exit must win
    do_reset();
    bus.req = 4'b1011;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
    for (int i = 0; i < 5; i++) brew(i, 2 + i, 4'b1011);
    brew(LT - 1, RT, 4'b1011);
    bus.req = '0;
    chk("fair_cnt", bus.served_count, 6);
    last = 3;
    exp_cnt = 6;

    // leave timeout
    bus.req = 4'b0001;
    start_brew(g);
    chk("lt_grant", g, 4'b0001);
    bus.req = '0;
    n = 1;
    while (bus.error !== 1'b1 && n < LT + 10) begin
      step();
      n++;
      if (bus.done !== '0) chk("lt_no_done", bus.done, 0);
    end
    chk("lt_cycles", n, LT + 1);
    chk("lt_grant_held", bus.grant, 4'b0001);
    chk("lt_busy", bus.busy, 0);
    bus.machine_state = 4'd3;
    step();
    chk("lt_sticky", bus.error, 1);
    clear_err();

    // illegal state in RUN
    bus.req = 4'b0010;
    start_brew(g);
    chk("ill_grant", g, 4'b0010);
    bus.machine_state = 4'd2;
    step();
    chk("ill_busy_run", bus.busy, 1);
    bus.machine_state = 4'd12;
    step();
    chk("ill_error", bus.error, 1);
    chk("ill_grant_held", bus.grant, 4'b0010);
    chk("ill_no_done", bus.done, 0);
    clear_err();

    // run timeout with machine stuck at 5
    bus.req = 4'b0100;
    start_brew(g);
    chk("rt_grant", g, 4'b0100);
    bus.machine_state = 4'd5;
    step();
    n = 1;
    while (bus.error !== 1'b1 && n < RT + 10) begin
      step();
      n++;
    end
    chk("rt_cycles", n, RT + 1);
    chk("rt_grant_held", bus.grant, 4'b0100);
    clear_err();

    // illegal state while waiting to leave IDLE
    bus.req = 4'b1000;
    start_brew(g);
    bus.machine_state = 4'd0;
    step();
    chk("ill_leave_error", bus.error, 1);
    chk("ill_leave_grant", bus.grant, 4'b1000);
    clear_err();
    chk("err_cnt", bus.served_count, exp_cnt);

    // failed brews must not move the pointer
    model_brew(4'b1111, 1, 3, 4'b1111);
    bus.req = '0;
    chk("ptr_after_err_cnt", bus.served_count, exp_cnt);

    // reset in the middle of RUN
    bus.req = 4'b0010;
    start_brew(g);
    bus.machine_state = 4'd3;
    step();
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    bus.machine_state = 4'd4;
    step();
    chk_reset_outputs("mid_rst");
    rst = 1'b0;
    bus.req = '0;
    bus.machine_state = 4'd1;
    step();
    chk("mid_rst_start_after", bus.start, 0);
    last = N - 1;
    exp_cnt = 0;

    // saturation of the narrow counter
    for (int i = 0; i < 5; i++) model_brew(4'b1111, i % 3, 1 + i, 4'b1111);
    bus.req = '0;
    chk("sat_cnt_wide", bus.served_count, 5);
    chk("sat_cnt_narrow", bus2.served_count, 3);

    // randomized brews against the reference rule
    for (int i = 0; i < 30; i++) begin
      r = 4'($urandom_range(15, 1));
      model_brew(r, $urandom_range(LT - 1, 0), $urandom_range(12, 1), 4'($urandom_range(15, 0)));
      bus.req = '0;
    end
    chk("rand_cnt_wide", bus.served_count, exp_cnt);
    chk("rand_cnt_narrow", bus2.served_count, (exp_cnt > 3) ? 3 : exp_cnt);
    chk("rand_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cafe_arbiter.md
# cafe_arbiter

Round-robin arbiter and sequencer that shares one `maquina_maluca` coffee machine between `N_REQ` order requesters. It waits for the machine to report IDLE (state 1) and grants one requester. It then pulses the machine's `start` and tracks the brew cycle until the machine returns to IDLE. Completion, a saturating served-drink count, and timeout/illegal-state errors are reported. It sits between the order-entry logic and the machine's `start`/`state` ports.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `LEAVE_TO`, 8: max cycles allowed after `start` for the machine to leave IDLE.
- `RUN_TO`, 64: max cycles allowed from leaving IDLE until it returns to IDLE.
- `CNT_W`, 8: width of `served_count`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: level requests, one bit per requester.
- `err_clr` in 1: clears the sticky error; only acted on in ERR.
- `machine_state` in 4: the machine's `state` output (legal 1..9, IDLE = 1).
- `start` out 1: drive to the machine's `start`.
- `grant` out N_REQ: one-hot owner of the current brew; zero when there is no owner.
- `done` out N_REQ: one-cycle pulse on the bit of the requester whose brew completed.
- `busy` out 1: high in START, LEAVE, RUN, DONE.
- `error` out 1: high in ERR.
- `served_count` out CNT_W: completed brews, saturating at all-ones.

## Operation
- FSM states and transitions:
  - ARB: if `req != 0` and `machine_state == 1`, load `grant` with the round-robin winner and go to START. Otherwise stay.
  - START: `start = 1` for exactly this one cycle. Clear the timer and go to LEAVE.
  - LEAVE:
    - `machine_state` in 2..9: clear the timer and go to RUN.
    - `machine_state` 0 or 10..15: go to ERR.
    - Timer reaches `LEAVE_TO` while still 1: go to ERR.
  - RUN:
    - `machine_state == 1`: go to DONE.
    - `machine_state` 0 or 10..15: go to ERR.
    - Timer reaches `RUN_TO`: go to ERR.
    - Revisiting states (e.g. 3→4→3) is legal.
  - DONE (one cycle):
    - `done = grant`.
    - `served_count` increments, holding if all-ones.
    - Round-robin pointer is set to the granted index.
    - Go to ARB; `grant` is cleared on exit.
  - ERR:
    - `error = 1`, `start = 0`; `grant` is held to identify the failed owner.
    - No `done`, no count.
    - `err_clr` clears `grant` and goes to ARB.
- Round robin:
  - Search starts at pointer+1 and wraps modulo `N_REQ`; the first set `req` bit wins.
  - Pointer resets to `N_REQ-1`, so requester 0 wins first.
- `req` is sampled only in ARB. Dropping `req` after grant does not abort the brew. A requester holding `req` continuously is re-served only after every other pending requester.
- Startup: the machine may sit in state 0 after its own reset. The arbiter does not grant while `machine_state != 1`, and this is not an error in ARB.
- Timer counts cycles spent in LEAVE/RUN. It is wide enough for `max(LEAVE_TO, RUN_TO)`.

## Timing
- Reset values: FSM = ARB, `start` 0, `grant` 0, `done` 0, `busy` 0, `error` 0, `served_count` 0, pointer `N_REQ-1`.
- `rst` mid-brew: on the next edge all of the above apply; `start` is never high the cycle after `rst`.
- All outputs come from registered state. `start`/`busy`/`error`/`done` are decoded from the FSM state only, with no input-to-output combinational path.
- Latency:
  - `req` and `machine_state == 1` seen at edge E (in ARB): `grant` and `start` are high in the cycle after E.
  - `start` is low from E+1.
  - `done` is high in the cycle after the edge that samples `machine_state == 1` in RUN.
  - Next grant is possible no earlier than 2 cycles after `done`.
- Timeout:
  - ERR is entered on the edge where the timer equals `LEAVE_TO` (or `RUN_TO`) and the exit condition is absent.
  - A legal exit sampled on that same edge takes priority over the timeout.
- Simultaneous events:
  - Illegal state and timeout on the same edge: go to ERR.
  - `err_clr` outside ERR: ignored.
  - `err_clr` held into ARB: no effect.

## Test plan
- Single order: reset, `req=4'b0001` with the machine model walking 0→1, then 2,3,4,3,5,6,7,8,9,1 after start. Required: `start` high exactly 1 cycle, `grant=0001` throughout, `done=0001` for 1 cycle, `served_count=1`.
- Fairness: `req=4'b1011` held for 6 brews. Required grant order 0,1,3,0,1,3; `served_count=6`.
- Startup gate: machine held at state 0 for 10 cycles with `req=0001`. Required: `start` stays 0; grant is issued only after state becomes 1.
- Leave timeout: machine stays at 1 after `start`. Required: `error=1` exactly `LEAVE_TO` cycles after leaving START, `grant` held, no `done`. Then `err_clr=1` gives `error=0` and `grant=0` next cycle.
- Illegal/run timeout: state goes to 12 in RUN, giving ERR. Separately, state stuck at 5 gives ERR after `RUN_TO` cycles, and `served_count` is unchanged.
- Reset mid-brew and saturation: `rst` while in RUN gives all outputs at reset values next cycle. With `CNT_W=2`, five brews leave `served_count=3`.
